if_fetch: RTL and testbench

Instruction-fetch stage of the Osiris I pipeline. It owns the program counter, issues single-outstanding word requests to instruction memory over a req/gnt/rvalid handshake, and presents {pc, pc+4, instruction, valid} to the IF/ID pipeline register. It honours hazard-unit stalls and EX-stage redirects, and discards responses that become stale after a redirect.

---
 rtl/osiris_i_pkg.sv | 24 ++
 rtl/if_fetch.sv | 141 ++++++++++++++
 tb/tb_if_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/osiris_i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osiris_i_pkg
// Description : Shared types and constants for the Osiris I pipeline.
//               Holds the fetch FSM state type, the canonical NOP encoding
//               and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package osiris_i_pkg;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch FSM. Explicit 2-bit encoding keeps the state register width fixed.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // request pending at r_pc
      S_WAIT = 2'd1,   // granted, waiting for the response
      S_HOLD = 2'd2,   // instruction buffered and presented
      S_DROP = 2'd3    // granted request made stale by a redirect
   } fetch_state_t;

endpackage : osiris_i_pkg
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Owns the program counter, issues a
//               single outstanding word request per fetch over a
//               req/gnt/rvalid handshake, and presents {pc, pc+4, instr,
//               valid} to the IF/ID register. Honours hazard stalls and EX
//               redirects, discarding responses made stale by a redirect.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_stall_IF          - hold the presented instruction
//               i_pcsrc_EX          - one-cycle redirect strobe
//               i_pctarget_EX       - redirect target (word aligned)
//               o_imem_req/addr     - fetch request and address
//               i_imem_gnt          - request accepted this cycle
//               i_imem_rvalid/rdata - instruction response
//               o_pc_IF, o_pcplus4_IF, o_instr_IF, o_instr_valid_IF
//                                   - presented fetch packet
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
   import osiris_i_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_stall_IF,
   input  logic                  i_pcsrc_EX,
   input  logic [DATA_WIDTH-1:0] i_pctarget_EX,
   output logic                  o_imem_req,
   output logic [DATA_WIDTH-1:0] o_imem_addr,
   input  logic                  i_imem_gnt,
   input  logic                  i_imem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_imem_rdata,
   output logic [DATA_WIDTH-1:0] o_pc_IF,
   output logic [DATA_WIDTH-1:0] o_pcplus4_IF,
   output logic [DATA_WIDTH-1:0] o_instr_IF,
   output logic                  o_instr_valid_IF
);

   localparam logic [DATA_WIDTH-1:0] c_four       = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] c_align_mask = ~DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] c_nop        = DATA_WIDTH'(NOP_INSTR);

   fetch_state_t          r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_instr;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic [DATA_WIDTH-1:0] w_target;
   logic                  w_advance;

   // Addition wraps naturally modulo 2^DATA_WIDTH.
   assign w_pc_plus4 = r_pc + c_four;
   // Low bits forced to zero so r_pc stays word aligned even on a bad target.
   assign w_target   = i_pctarget_EX & c_align_mask;
   // In S_HOLD, the held instruction retires into IF/ID and the next fetch
   // is launched in the same cycle.
   assign w_advance  = (r_state == S_HOLD) && !i_pcsrc_EX && !i_stall_IF;

   // ------------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------------
   always_comb begin
      o_imem_req  = 1'b0;
      o_imem_addr = r_pc;
      if (r_state == S_REQ) begin
         o_imem_req = 1'b1;
      end else if (w_advance) begin
         o_imem_req  = 1'b1;
         o_imem_addr = w_pc_plus4;
      end
      // Memory shares rst; never hand it a request while it is resetting.
      if (rst) begin
         o_imem_req = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Presented packet: registered state only, no path from i_imem_rdata.
   // ------------------------------------------------------------------------
   always_comb begin
      o_instr_valid_IF = (r_state == S_HOLD);
      o_pc_IF          = r_pc;
      o_pcplus4_IF     = w_pc_plus4;
      o_instr_IF       = o_instr_valid_IF ? r_instr : c_nop;
   end

   // ------------------------------------------------------------------------
   // FSM, PC and instruction buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_instr <= c_nop;
      end else begin
         unique case (r_state)
            S_REQ: begin
               if (i_pcsrc_EX) begin
                  r_pc <= w_target;
                  // A granted request for the old PC must have its data dropped.
                  r_state <= i_imem_gnt ? S_DROP : S_REQ;
               end else if (i_imem_gnt) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_pcsrc_EX) begin
                  r_pc    <= w_target;
                  r_state <= i_imem_rvalid ? S_REQ : S_DROP;
               end else if (i_imem_rvalid) begin
                  r_instr <= i_imem_rdata;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (i_pcsrc_EX) begin
                  r_pc    <= w_target;
                  r_state <= S_REQ;
               end else if (!i_stall_IF) begin
                  r_pc    <= w_pc_plus4;
                  r_state <= i_imem_gnt ? S_WAIT : S_REQ;
               end
            end
            S_DROP: begin
               if (i_pcsrc_EX) begin
                  r_pc    <= w_target;
                  r_state <= i_imem_rvalid ? S_REQ : S_DROP;
               end else if (i_imem_rvalid) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch. Memory handshake
//               is driven cycle by cycle from hand-written vectors; expected
//               values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

   localparam logic [31:0] c_nop = 32'h0000_0013;
   localparam logic [31:0] c_i0  = 32'h00A0_0093;
   localparam logic [31:0] c_i1  = 32'h0010_0113;
   localparam logic [31:0] c_i2  = 32'h0020_0193;
   localparam logic [31:0] c_i3  = 32'h0030_0213;
   localparam logic [31:0] c_i4  = 32'h0040_0293;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        pcsrc = 1'b0;
   logic [31:0] target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic [31:0] pc_IF;
   logic [31:0] pcplus4_IF;
   logic [31:0] instr_IF;
   logic        valid_IF;

   int total = 0;
   int bad   = 0;

   if_fetch #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .i_stall_IF       (stall),
      .i_pcsrc_EX       (pcsrc),
      .i_pctarget_EX    (target),
      .o_imem_req       (imem_req),
      .o_imem_addr      (imem_addr),
      .i_imem_gnt       (gnt),
      .i_imem_rvalid    (rvalid),
      .i_imem_rdata     (rdata),
      .o_pc_IF          (pc_IF),
      .o_pcplus4_IF     (pcplus4_IF),
      .o_instr_IF       (instr_IF),
      .o_instr_valid_IF (valid_IF)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven and outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic ps, input logic [31:0] tg, input logic st);
      gnt = g; rvalid = rv; rdata = rd; pcsrc = ps; target = tg; stall = st;
      #1;
   endtask

   task automatic chk_pkt(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] ins);
      check({tag, ".valid"}, {31'd0, valid_IF}, {31'd0, v});
      check({tag, ".pc"},    pc_IF,             pc);
      check({tag, ".pc4"},   pcplus4_IF,        pc + 32'd4);
      check({tag, ".instr"}, instr_IF,          ins);
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
      check({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
      if (r) check({tag, ".addr"}, imem_addr, a);
   endtask

   initial begin
      // ---- reset ----
      tick(); tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_pkt("rst", 0, 32'h0, c_nop);
      chk_req("rst", 0, 0);

      // ---- first fetch, zero-wait memory ----
      rst = 1'b0;
      drive(1, 0, 0, 0, 0, 0);                 // cycle 0: request at 0
      chk_req("c0", 1, 32'h0);
      chk_pkt("c0", 0, 32'h0, c_nop);
      tick(); drive(0, 1, c_i0, 0, 0, 0);      // cycle 1: S_WAIT, response
      chk_req("c1", 0, 0);
      chk_pkt("c1", 0, 32'h0, c_nop);
      tick(); drive(1, 0, 0, 0, 0, 0);         // cycle 2: valid, fetch 0x4
      chk_pkt("c2", 1, 32'h0, c_i0);
      chk_req("c2", 1, 32'h4);
      tick(); drive(0, 1, c_i1, 0, 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0);         // hold pc 4, fetch 0x8
      chk_pkt("pc4", 1, 32'h4, c_i1);
      chk_req("pc4", 1, 32'h8);
      tick(); drive(0, 1, c_i2, 0, 0, 0);

      // ---- stall 3 cycles at pc 0x8 ----
      for (int i = 0; i < 3; i++) begin
         tick(); drive(0, 0, 0, 0, 0, 1);
         chk_pkt("stall", 1, 32'h8, c_i2);
         chk_req("stall", 0, 0);
      end
      tick(); drive(1, 0, 0, 0, 0, 0);         // release: fetch 0xC now
      chk_pkt("rel", 1, 32'h8, c_i2);
      chk_req("rel", 1, 32'hC);

      // ---- redirect in S_WAIT without rvalid, stale response later ----
      tick(); drive(0, 0, 0, 1, 32'h100, 0);
      chk_pkt("rdw", 0, 32'hC, c_nop);
      tick(); drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      chk_pkt("drop", 0, 32'h100, c_nop);
      chk_req("drop", 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0);
      chk_pkt("r100", 0, 32'h100, c_nop);
      chk_req("r100", 1, 32'h100);

      // ---- redirect coincident with rvalid in S_WAIT ----
      tick(); drive(0, 1, 32'hDEAD_BEEF, 1, 32'h40, 0);
      chk_pkt("rdv", 0, 32'h100, c_nop);
      tick(); drive(0, 0, 0, 0, 0, 0);

      // ---- gnt withheld 4 cycles, redirect in the last one ----
      for (int i = 0; i < 4; i++) begin
         chk_req("nogt", 1, 32'h40);
         chk_pkt("nogt", 0, 32'h40, c_nop);
         if (i == 3) drive(0, 0, 0, 1, 32'h80, 0);
         tick(); drive(0, 0, 0, 0, 0, 0);
      end
      drive(1, 0, 0, 0, 0, 0);
      chk_req("r80", 1, 32'h80);
      tick(); drive(0, 1, c_i3, 0, 0, 0);
      tick(); drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0); // redirect from S_HOLD
      chk_pkt("h80", 1, 32'h80, c_i3);

      // ---- PC wrap ----
      tick(); drive(1, 0, 0, 0, 0, 0);
      chk_req("rfc", 1, 32'hFFFF_FFFC);
      chk_pkt("rfc", 0, 32'hFFFF_FFFC, c_nop);
      tick(); drive(0, 1, c_i4, 0, 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0);
      check("wrap.pc4", pcplus4_IF, 32'h0);
      chk_pkt("wrap", 1, 32'hFFFF_FFFC, c_i4);
      chk_req("wrap", 1, 32'h0);
      tick(); drive(0, 1, c_i0, 0, 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0);
      chk_pkt("pc0", 1, 32'h0, c_i0);
      tick(); drive(0, 0, 0, 0, 0, 0);       // S_WAIT at pc 4

      // ---- reset mid-transaction ----
      chk_pkt("pre", 0, 32'h4, c_nop);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk_req("mrst", 0, 0);
      tick(); drive(0, 0, 0, 0, 0, 0);
      chk_pkt("mrst", 0, 32'h0, c_nop);
      chk_req("mrst2", 0, 0);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk_req("post", 1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_if_fetch
`default_nettype wire
